// File: rtl/md5_block_padder_pkg.sv
// Shared constants and FSM encoding for the MD5 single-block padder.
package md5_block_padder_pkg;

  localparam int unsigned MD5_BLOCK_W      = 512;
  localparam logic [7:0]  MD5_PAD_BYTE     = 8'h80;
  localparam int unsigned MD5_LEN_LSB_BYTE = 56;
  localparam int unsigned MD5_MAX_BYTES    = 55;

  typedef enum logic {
    StCollect = 1'b0,
    StHold    = 1'b1
  } pad_state_e;

endpackage

// File: rtl/md5_block_padder_if.sv
// Byte-stream input and padded-block output bundle of the MD5 padder.
interface md5_block_padder_if;
  import md5_block_padder_pkg::*;

  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ready;
  logic [MD5_BLOCK_W-1:0] m_out;
  logic                   valid_out;
  logic                   err_out;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, m_out, valid_out, err_out
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, m_out, valid_out, err_out
  );

endinterface

// File: rtl/md5_byte_lane_wr.sv
// 64-lane byte write decoder: lane 0 is the most significant byte of the block.
module md5_byte_lane_wr
  import md5_block_padder_pkg::*;
(
  input  logic [MD5_BLOCK_W-1:0] blk_in,
  input  logic [5:0]             idx,
  input  logic [7:0]             wr_byte,
  input  logic                   we,
  output logic [MD5_BLOCK_W-1:0] blk_out
);

  always_comb begin
    blk_out = blk_in;
    for (int i = 0; i < MD5_BLOCK_W / 8; i++) begin
      if (we && (idx == 6'(i))) begin
        blk_out[MD5_BLOCK_W-1-8*i -: 8] = wr_byte;
      end
    end
  end

endmodule

// File: rtl/md5_block_padder.sv
// Collects a message byte-per-cycle and emits one padded MD5 block as a strobe.
module md5_block_padder
  import md5_block_padder_pkg::*;
#(
  parameter int unsigned MAX_BYTES = MD5_MAX_BYTES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  md5_block_padder_if.slave  bus
);

  localparam logic [6:0] MaxCnt = 7'(MAX_BYTES);
  localparam logic [6:0] SatCnt = 7'd64;

  pad_state_e             state_q, state_d;
  logic [6:0]             byte_cnt_q, byte_cnt_d;
  logic                   ovf_q, ovf_d;
  logic [MD5_BLOCK_W-1:0] buffer_q, buffer_d;
  logic [MD5_BLOCK_W-1:0] m_out_q, m_out_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic                   accept;
  logic                   over;
  logic                   lane_we;
  logic [6:0]             cnt_inc;
  logic [6:0]             pad_len;
  logic [15:0]            bit_len;
  logic [MD5_BLOCK_W-1:0] buf_wr;
  logic [MD5_BLOCK_W-1:0] pad_src;
  logic [MD5_BLOCK_W-1:0] block;

  assign bus.in_ready  = reset_n && (state_q == StCollect);
  assign bus.m_out     = m_out_q;
  assign bus.valid_out = valid_q;
  assign bus.err_out   = err_q;

  assign accept  = bus.in_valid && bus.in_ready;
  // The byte being accepted counts toward overflow, so a too-long final byte errors at once.
  assign over    = ovf_q || (byte_cnt_q >= MaxCnt);
  assign cnt_inc = (byte_cnt_q == SatCnt) ? SatCnt : byte_cnt_q + 7'd1;
  assign lane_we = accept && !over;

  md5_byte_lane_wr u_lane_wr (
    .blk_in  (buffer_q),
    .idx     (byte_cnt_q[5:0]),
    .wr_byte (bus.in_data),
    .we      (lane_we),
    .blk_out (buf_wr)
  );

  // HOLD pads the stored message; COLLECT pads the buffer including the byte just arriving.
  always_comb begin
    pad_src = (state_q == StHold) ? buffer_q : buf_wr;
    pad_len = (state_q == StHold) ? byte_cnt_q : cnt_inc;
    bit_len = {6'd0, pad_len, 3'd0};
    block   = pad_src;
    for (int i = 0; i < int'(MD5_LEN_LSB_BYTE); i++) begin
      if (pad_len == 7'(i)) begin
        block[MD5_BLOCK_W-1-8*i -: 8] = MD5_PAD_BYTE;
      end
    end
    block[MD5_BLOCK_W-1-8*MD5_LEN_LSB_BYTE -: 8]     = bit_len[7:0];
    block[MD5_BLOCK_W-1-8*(MD5_LEN_LSB_BYTE+1) -: 8] = bit_len[15:8];
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    ovf_d      = ovf_q;
    buffer_d   = buffer_q;
    m_out_d    = m_out_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (accept) begin
          if (!bus.in_last) begin
            buffer_d   = buf_wr;
            byte_cnt_d = cnt_inc;
            ovf_d      = over;
          end else if (over) begin
            err_d      = 1'b1;
            byte_cnt_d = '0;
            ovf_d      = 1'b0;
            buffer_d   = '0;
          end else if (en) begin
            m_out_d    = block;
            valid_d    = 1'b1;
            byte_cnt_d = '0;
            buffer_d   = '0;
          end else begin
            buffer_d   = buf_wr;
            byte_cnt_d = cnt_inc;
            state_d    = StHold;
          end
        end
      end
      StHold: begin
        if (en) begin
          m_out_d    = block;
          valid_d    = 1'b1;
          byte_cnt_d = '0;
          buffer_d   = '0;
          state_d    = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StCollect;
      byte_cnt_q <= '0;
      ovf_q      <= 1'b0;
      buffer_q   <= '0;
      m_out_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      ovf_q      <= ovf_d;
      buffer_q   <= buffer_d;
      m_out_q    <= m_out_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

endmodule
